mul_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the EX-stage multiply (ALU control code 5 = mul) in the 5-stage RISC-V pipeline.
- Replaces the single-cycle multiplier with an iterative shift-add engine.
- Stalls the pipeline while the product is computed, then presents the low DATA_WIDTH bits of the product for EX/MEM writeback.
- Non-mul ALU codes pass untouched; this block ignores them.

---
 rtl/mul_seq_ctrl.sv | 141 ++++++++++++++
 tb/tb_mul_seq_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// Iterative shift-add sequencer for the EX-stage mul: stalls the pipeline while the
// product is built, then pulses done_o with the low DATA_WIDTH bits. Optional macro: MUL_EARLY_TERM_EN.
module mul_seq_ctrl #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [2:0]  MUL_CODE   = 3'd5,
  parameter int          CNT_WIDTH  = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [2:0]            ALUCtrl_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  output logic                  stall_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t                state_r;
  logic [DATA_WIDTH-1:0] mcand_r;
  logic [DATA_WIDTH-1:0] mplier_r;
  logic [DATA_WIDTH-1:0] acc_r;
  logic [CNT_WIDTH-1:0]  cnt_r;
  logic [DATA_WIDTH-1:0] result_r;
  logic                  busy_r;
  logic                  done_r;

  logic                  start_s;
  logic [DATA_WIDTH-1:0] acc_next_s;
  logic [DATA_WIDTH-1:0] mplier_shift_s;
  logic                  last_iter_s;
  logic                  stall_s;

  // Request decode and the datapath value produced by the current RUN iteration
  always_comb begin
    start_s        = valid_i & (ALUCtrl_i == MUL_CODE) & ~flush_i;
    mplier_shift_s = mplier_r >> 1;
    if (mplier_r[0]) begin
      acc_next_s = acc_r + mcand_r;
    end else begin
      acc_next_s = acc_r;
    end
`ifdef MUL_EARLY_TERM_EN
    // Stop once no set multiplier bits remain after this iteration
    last_iter_s = (cnt_r == LAST_CNT) | (mplier_shift_s == '0);
`else
    last_iter_s = (cnt_r == LAST_CNT);
`endif
  end

  // Stall must cover the request cycle itself, so it is decoded from state and inputs
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      ST_IDLE: stall_s = start_s;
      ST_RUN:  stall_s = ~flush_i;
      ST_DONE: stall_s = 1'b0;
      default: stall_s = 1'b0;
    endcase
  end

  // Sequencer FSM with datapath registers and registered status outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= ST_IDLE;
      mcand_r  <= '0;
      mplier_r <= '0;
      acc_r    <= '0;
      cnt_r    <= '0;
      result_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start_s) begin
            mcand_r  <= rs1_data_i;
            mplier_r <= rs2_data_i;
            acc_r    <= '0;
            cnt_r    <= '0;
            busy_r   <= 1'b1;
            state_r  <= ST_RUN;
          end else begin
            busy_r   <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (flush_i) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            acc_r    <= acc_next_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_shift_s;
            cnt_r    <= cnt_r + CNT_ONE;
            busy_r   <= 1'b1;
            if (last_iter_s) begin
              result_r <= acc_next_s;
              done_r   <= 1'b1;
              state_r  <= ST_DONE;
            end else begin
              done_r   <= 1'b0;
              state_r  <= ST_RUN;
            end
          end
        end
        ST_DONE: begin
          // Always back to IDLE so the instruction leaving EX cannot retrigger
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign stall_o  = stall_s;
  assign busy_o   = busy_r;
  assign done_o   = done_r;
  assign result_o = result_r;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: stimulus tasks queue expected products and done
// cycles, a negedge monitor checks every done_o pulse against the queue.
module tb_mul_seq_ctrl;

  logic        clk;
  logic        rst_i;
  logic        valid_i;
  logic [2:0]  ALUCtrl_i;
  logic        flush_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] exp_res_q[$];
  int          exp_cyc_q[$];

  mul_seq_ctrl dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .ALUCtrl_i  (ALUCtrl_i),
    .flush_i    (flush_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .stall_o    (stall_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_iters(input logic [31:0] b);
    int n;
`ifdef MUL_EARLY_TERM_EN
    n = 1;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
`else
    n = 32;
`endif
    return n;
  endfunction

  // Monitor: every done_o pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst_i && done_o === 1'b1) begin
      if (exp_res_q.size() == 0) begin
        check("unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
      end else begin
        check("done_result", 64'(result_o), 64'(exp_res_q.pop_front()));
        check("done_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
      end
    end
  end

  // Issue one mul, keep garbage mul requests on the inputs while busy, return in the DONE cycle
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int t;
    int stall_cycles;
    bit ended;
    @(posedge clk); #1;
    valid_i = 1'b1; ALUCtrl_i = 3'd5; flush_i = 1'b0;
    rs1_data_i = a; rs2_data_i = b;
    t = cyc;
    exp_res_q.push_back(exp);
    exp_cyc_q.push_back(t + exp_iters(b) + 1);
    stall_cycles = 0;
    ended = 1'b0;
    for (int k = 0; k < 40 && !ended; k++) begin
      @(negedge clk);
      if (stall_o === 1'b1) begin
        stall_cycles++;
        @(posedge clk); #1;
        rs1_data_i = $urandom; rs2_data_i = $urandom;
      end else begin
        ended = 1'b1;
      end
    end
    check("stall_cycles", 64'(stall_cycles), 64'(exp_iters(b) + 1));
    check("done_cycle_busy", 64'(busy_o), 64'd1);
    valid_i = 1'b0; ALUCtrl_i = 3'd0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) @(posedge clk);
  endtask

  initial begin
    int t;
    rst_i = 1'b1; valid_i = 1'b1; ALUCtrl_i = 3'd3; flush_i = 1'b0;
    rs1_data_i = 32'd7; rs2_data_i = 32'd6;

    // Reset two cycles with a non-mul on the inputs
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rst_stall", 64'(stall_o), 64'd0);
      check("rst_done", 64'(done_o), 64'd0);
      check("rst_result", 64'(result_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
    end
    @(posedge clk); #1; rst_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("nonmul_stall", 64'(stall_o), 64'd0);
      check("nonmul_busy", 64'(busy_o), 64'd0);
      check("nonmul_result", 64'(result_o), 64'd0);
      @(posedge clk); #1;
    end
    valid_i = 1'b0;

    // Mul code without valid: no action
    ALUCtrl_i = 3'd5;
    @(negedge clk);
    check("novalid_stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    ALUCtrl_i = 3'd0;

    do_mul(32'd7, 32'd6, 32'd42);
    @(negedge clk);
    check("busy_after_done", 64'(busy_o), 64'd0);
    check("result_hold", 64'(result_o), 64'd42);

    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    do_mul(32'h8000_0000, 32'd2, 32'h0000_0000);
    do_mul(32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001);
    do_mul(32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1);
    do_mul(32'd9, 32'd3, 32'd27);
    do_mul(32'd123, 32'd0, 32'd0);
    do_mul(32'd1, 32'h8000_0001, 32'h8000_0001);

    // Back-to-back: second mul presented the cycle after DONE
    idle_cycles(2);
    do_mul(32'd3, 32'd5, 32'd15);
    do_mul(32'd10, 32'd10, 32'd100);

    // Flush in IDLE suppresses start
    @(posedge clk); #1;
    valid_i = 1'b1; ALUCtrl_i = 3'd5; flush_i = 1'b1; rs1_data_i = 32'd4; rs2_data_i = 32'd4;
    @(negedge clk);
    check("flush_idle_stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", 64'(busy_o), 64'd0);

    // Flush mid-RUN at T+10
    @(posedge clk); #1;
    valid_i = 1'b1; ALUCtrl_i = 3'd5; rs1_data_i = 32'd11; rs2_data_i = 32'd11;
    t = cyc;
    @(posedge clk); #1;
    valid_i = 1'b0;
    while (cyc < t + 10) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_run_busy", 64'(busy_o), 64'd0);
    check("flush_run_stall", 64'(stall_o), 64'd0);
    check("flush_run_done", 64'(done_o), 64'd0);
    check("flush_run_result", 64'(result_o), 64'd100);
    idle_cycles(40);

    // Reset mid-RUN at T+20
    @(posedge clk); #1;
    valid_i = 1'b1; ALUCtrl_i = 3'd5; rs1_data_i = 32'd13; rs2_data_i = 32'd17;
    t = cyc;
    @(posedge clk); #1;
    valid_i = 1'b0;
    while (cyc < t + 20) begin @(posedge clk); #1; end
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_stall", 64'(stall_o), 64'd0);
    check("midrst_done", 64'(done_o), 64'd0);
    check("midrst_result", 64'(result_o), 64'd0);
    idle_cycles(40);

    // Recovery after reset
    do_mul(32'd6, 32'd7, 32'd42);
    idle_cycles(3);

    check("missing_done", 64'(exp_res_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
